// File: rtl/bus_slave_port.sv
// bus_slave_port: serial slave endpoint that shifts in an address and write data or shifts out read data.
// Optional even parity on data is enabled with SLAVE_PARITY_EN.
module bus_slave_port #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 2
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SEL,
  input  logic B_UTIL,
  input  logic B_RW,
  input  logic B_BUS_OUT,
  output logic B_BUS_IN,
  output logic B_READY,
  output logic B_ACK,
  output logic B_SBSY,
  output logic ERR
);
`ifdef SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int DW = DATA_W + PAR;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int M1 = ADDR_W > DW ? ADDR_W : DW;
  localparam int MX = M1 > READ_LAT ? M1 : READ_LAT;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] L_LAST = CW'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RWAIT, RDATA, DONE} state_t;

  state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr, w_addr_sh;
  logic [DW-1:0] r_sh, w_sh, w_rd_sh;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_rd;
  logic w_we, w_perr, w_abort;

  assign w_addr_sh = {B_BUS_OUT, r_addr[ADDR_W-1:1]};
  // The read word is fetched with the final address bit so it is ready on entry to RWAIT/RDATA.
  assign w_rd = r_mem[w_addr_sh[AW-1:0]];
`ifdef SLAVE_PARITY_EN
  assign w_rd_sh = {^w_rd, w_rd};
  assign w_perr  = (^r_sh[DATA_W-1:0]) != r_sh[DATA_W];
`else
  assign w_rd_sh = w_rd;
  assign w_perr  = 1'b0;
`endif
  assign w_abort = !SEL && r_state != IDLE && r_state != DONE;

  always_comb begin
    w_nxt    = r_state;
    w_cnt    = r_cnt;
    w_addr   = r_addr;
    w_sh     = r_sh;
    w_we     = 1'b0;
    B_ACK    = 1'b0;
    ERR      = 1'b0;
    B_READY  = r_state == IDLE;
    B_SBSY   = r_state == RWAIT;
    B_BUS_IN = r_state == RDATA && r_sh[0];
    case (r_state)
      IDLE: if (SEL && B_UTIL) begin
        w_addr = w_addr_sh;
        w_cnt  = CW'(1);
        w_nxt  = ADDR;
      end
      ADDR: if (B_UTIL) begin
        w_addr = w_addr_sh;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == A_LAST) begin
          w_cnt = '0;
          w_sh  = w_rd_sh;
          w_nxt = B_RW ? WDATA : (READ_LAT > 0 ? RWAIT : RDATA);
        end
      end
      WDATA: if (B_UTIL) begin
        w_sh  = {B_BUS_OUT, r_sh[DW-1:1]};
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == D_LAST) begin
          w_cnt = '0;
          w_nxt = WRITE;
        end
      end
      WRITE: begin
        w_we  = !w_perr;
        B_ACK = !w_perr;
        ERR   = w_perr;
        w_nxt = DONE;
      end
      RWAIT: begin
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == L_LAST) begin
          w_cnt = '0;
          w_nxt = RDATA;
        end
      end
      RDATA: begin
        w_sh  = r_sh >> 1;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == D_LAST) begin
          B_ACK = 1'b1;
          w_cnt = '0;
          w_nxt = DONE;
        end
      end
      DONE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_nxt = IDLE;
      w_cnt = '0;
      w_we  = 1'b0;
      B_ACK = 1'b0;
      ERR   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_sh    <= w_sh;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[r_addr[AW-1:0]] <= r_sh[DATA_W-1:0];
  end
endmodule
